discriminator_seq: RTL and testbench
====================================

// Module: discriminator_seq
// PURPOSE
//  Sequential 9-input discriminator network, used opposite the 3x3 generator in the GAN datapath.
//  - Accepts one 3x3 image as 9 fixed-point pixels streamed over a valid/ready handshake, in
//    raster order: y_1x1, y_1x2, ..., y_3x3.
//  - Evaluates a 9->N_HIDDEN->1 network with time-multiplexed MACs.
//  - Returns one signed score and a real/fake flag per image, held until the consumer accepts it.
// PARAMETERS
//  WIDTH     32  data width, signed two's complement fixed point
//  FRAC      16  fractional bits (Q(WIDTH-FRAC).FRAC)
//  N_PIXEL    9  pixels per image
//  N_HIDDEN   3  hidden neurons
// PORTS
//  clk        in   1                       clock, rising edge
//  rst        in   1                       asynchronous reset, active-low
//  in_valid   in   1                       pixel valid
//  in_ready   out  1                       block can accept a pixel
//  in_pixel   in   WIDTH                   pixel value, signed
//  w_L2       in   N_PIXEL*N_HIDDEN*WIDTH  hidden weights; hidden k, pixel p at slice index N_PIXEL*k+p
//  b_L2       in   N_HIDDEN*WIDTH          hidden biases; slice k
//  w_L3       in   N_HIDDEN*WIDTH          output weights; slice k
//  b_L3       in   WIDTH                   output bias
//  out_valid  out  1                       score valid
//  out_ready  in   1                       consumer accepts score
//  out_score  out  WIDTH                   signed score
//  out_real   out  1                       1 when out_score >= 0
// BEHAVIOUR
//  - Reset (rst=0, async): state LOAD; pixel count 0; all accumulators and hidden registers 0.
//    Outputs: out_valid=0, out_score=0, out_real=0, in_ready=1.
//  - Weights and biases are not registered. They must be stable from the first pixel accept until out_valid.
//  - FSM states: LOAD, ACT, OMAC, FIN, HOLD.
//  - LOAD: in_ready=1. An accept (in_valid&&in_ready) adds in_pixel*w_L2[N_PIXEL*k+cnt] to acc[k] for all k
//    in parallel, then cnt++. In-order accept: accept while cnt==N_PIXEL-1 goes to ACT.
//  - LOAD, in_valid=0: stall; no state change.
//  - ACT, 1 cycle: h[k] = act(sat((acc[k]>>>FRAC) + b_L2[k])).
//  - OMAC, N_HIDDEN cycles, index j=0..N_HIDDEN-1: oacc += h[j]*w_L3[j]. Goes to FIN after the last j.
//  - FIN, 1 cycle: out_score <= sat((oacc>>>FRAC) + b_L3); out_real <= ~sign; out_valid <= 1; goes to HOLD.
//  - Latency: out_valid rises N_HIDDEN+2 edges after the last-pixel accept edge (5 with defaults).
//  - HOLD: in_ready=0; out_valid, out_score and out_real held stable while out_ready=0.
//    On out_valid&&out_ready: out_valid<=0, all accumulators and cnt cleared, go to LOAD.
//    in_ready returns to 1 the next cycle. No pixel is accepted in the handshake cycle.
//  - Arithmetic:
//    - Products are full 2*WIDTH signed.
//    - acc and oacc are 2*WIDTH+4 bits; no overflow is possible for 9 terms.
//    - >>> is arithmetic shift (floor).
//    - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Intermediate values are computed at full width before sat.
//  - act(): ReLU, x<0 -> 0.
//  - Reset mid-frame discards all partial state. The next accepted pixel is pixel 0.
// CONFIGURATION
//  - DISC_LEAKY_RELU_EN defined: act(x) = x<0 ? x>>>3 : x (leaky ReLU, slope 1/8).
//  - DISC_LEAKY_RELU_EN undefined: plain ReLU.
//  - Latency and interface are identical in both builds.
// TESTING (FRAC=16, 1.0=0x00010000)
//  1. Assert rst=0 mid-run, then release -> out_valid=0, out_score=0, out_real=0, in_ready=1 in the same cycle.
//  2. All w=1.0, all b=0, 9 pixels=1.0 back-to-back, out_ready=1 ->
//     out_score=0x001B0000 (27.0), out_real=1, out_valid 5 edges after the 9th accept.
//  3. w_L2 all -1.0, pixels 1.0, w_L3 1.0, b_L3=-0.5 -> out_score=0xFFFF8000, out_real=0.
//     With DISC_LEAKY_RELU_EN: out_score=0xFFFC2000 (-3.875).
//  4. Case 2 with out_ready=0 for 10 cycles -> out_valid, out_score and out_real stable, in_ready=0.
//     On out_ready=1: one handshake, then in_ready=1 the next cycle.
//  5. Case 2 with random in_valid gaps, and rst pulsed after 4 pixels of a prior frame ->
//     result identical to case 2.
//  6. Pixels and all weights 0x7FFF0000, biases 0 -> out_score=0x7FFFFFFF, out_real=1. Negated w_L3 -> 0x80000000.

Source files
------------

// File: rtl/discriminator_seq.sv
// discriminator_seq: sequential 9->N_HIDDEN->1 GAN discriminator on a streamed 3x3 image
// Build option: define DISC_LEAKY_RELU_EN for leaky ReLU (slope 1/8), otherwise plain ReLU.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    pixel handshake, in_pixel signed Q(WIDTH-FRAC).FRAC, raster order
//   w_L2, b_L2           hidden weights (slice N_PIXEL*k+p) and biases (slice k), unregistered
//   w_L3, b_L3           output weights (slice k) and bias, unregistered
//   out_valid/out_ready  score handshake, out_score signed, out_real = score >= 0
module discriminator_seq #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 16,
   parameter int N_PIXEL  = 9,
   parameter int N_HIDDEN = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_pixel,
   input  logic [N_PIXEL*N_HIDDEN*WIDTH-1:0] w_L2,
   input  logic [N_HIDDEN*WIDTH-1:0]       b_L2,
   input  logic [N_HIDDEN*WIDTH-1:0]       w_L3,
   input  logic [WIDTH-1:0]                b_L3,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_score,
   output logic                            out_real
);
   localparam int AW = 2*WIDTH+4;
   localparam int SW = AW+1;
   localparam int CW = N_PIXEL > 1 ? $clog2(N_PIXEL) : 1;
   localparam int JW = N_HIDDEN > 1 ? $clog2(N_HIDDEN) : 1;
   localparam logic [CW-1:0] LAST_PIX = CW'(N_PIXEL-1);
   localparam logic [JW-1:0] LAST_J = JW'(N_HIDDEN-1);
   typedef enum logic [2:0] {S_LOAD, S_ACT, S_OMAC, S_FIN, S_HOLD} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [JW-1:0] r_j;
   logic signed [AW-1:0] r_acc [N_HIDDEN];
   logic signed [AW-1:0] r_oacc;
   logic signed [WIDTH-1:0] r_h [N_HIDDEN];
   logic signed [WIDTH-1:0] w_h [N_HIDDEN];
   logic signed [2*WIDTH-1:0] w_prod [N_HIDDEN];
   logic signed [2*WIDTH-1:0] w_oprod;
   logic signed [SW-1:0] w_fin;
   logic signed [WIDTH-1:0] w_score;
   logic r_valid, r_real;
   logic [WIDTH-1:0] r_score;
   // Values whose bits above WIDTH-1 are not pure sign extension are out of range.
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
      return (&x[SW-1:WIDTH-1] | ~|x[SW-1:WIDTH-1]) ? x[WIDTH-1:0] :
             x[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
   for (genvar k = 0; k < N_HIDDEN; k++) begin : g_hid
      logic signed [SW-1:0] w_pre;
      logic signed [WIDTH-1:0] w_sat;
      assign w_prod[k] = $signed(in_pixel) * $signed(w_L2[(N_PIXEL*k + int'(r_cnt))*WIDTH +: WIDTH]);
      assign w_pre = SW'(r_acc[k] >>> FRAC) + SW'($signed(b_L2[k*WIDTH +: WIDTH]));
      assign w_sat = sat(w_pre);
`ifdef DISC_LEAKY_RELU_EN
      assign w_h[k] = w_sat[WIDTH-1] ? (w_sat >>> 3) : w_sat;
`else
      assign w_h[k] = w_sat[WIDTH-1] ? '0 : w_sat;
`endif
   end
   assign w_oprod = r_h[r_j] * $signed(w_L3[int'(r_j)*WIDTH +: WIDTH]);
   assign w_fin = SW'(r_oacc >>> FRAC) + SW'($signed(b_L3));
   assign w_score = sat(w_fin);
   assign in_ready = r_state == S_LOAD;
   assign out_valid = r_valid;
   assign out_score = r_score;
   assign out_real = r_real;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD: w_next = (in_valid && r_cnt == LAST_PIX) ? S_ACT : S_LOAD;
         S_ACT: w_next = S_OMAC;
         S_OMAC: w_next = (r_j == LAST_J) ? S_FIN : S_OMAC;
         S_FIN: w_next = S_HOLD;
         S_HOLD: w_next = out_ready ? S_LOAD : S_HOLD;
         default: w_next = S_LOAD;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_LOAD;
         r_cnt <= '0;
         r_j <= '0;
         r_oacc <= '0;
         r_valid <= 1'b0;
         r_score <= '0;
         r_real <= 1'b0;
         for (int k = 0; k < N_HIDDEN; k++) begin
            r_acc[k] <= '0;
            r_h[k] <= '0;
         end
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LOAD: if (in_valid) begin
               for (int k = 0; k < N_HIDDEN; k++) r_acc[k] <= r_acc[k] + AW'(w_prod[k]);
               r_cnt <= (r_cnt == LAST_PIX) ? '0 : r_cnt + 1'b1;
            end
            S_ACT: for (int k = 0; k < N_HIDDEN; k++) r_h[k] <= w_h[k];
            S_OMAC: begin
               r_oacc <= r_oacc + AW'(w_oprod);
               r_j <= (r_j == LAST_J) ? '0 : r_j + 1'b1;
            end
            S_FIN: begin
               r_valid <= 1'b1;
               r_score <= w_score;
               r_real <= ~w_score[WIDTH-1];
            end
            S_HOLD: if (out_ready) begin
               r_valid <= 1'b0;
               r_cnt <= '0;
               r_oacc <= '0;
               for (int k = 0; k < N_HIDDEN; k++) r_acc[k] <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_discriminator_seq.sv
// tb_discriminator_seq: table, corner-case and randomized checks of discriminator_seq against a reference model
module tb_discriminator_seq;
   localparam int W = 32;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, out_real;
   logic [W-1:0] in_pixel = '0, out_score, b_L3;
   logic [9*3*W-1:0] w_L2;
   logic [3*W-1:0] b_L2, w_L3;
   logic [W-1:0] m_pix [9], m_w2 [27], m_b2 [3], m_w3 [3], m_b3;
   int checks = 0, failures = 0;
   typedef struct {
      string nm;
      logic [31:0] pix, w2, b2, w3, b3, es;
      logic er;
   } vec_t;
   vec_t tbl [7];
   for (genvar i = 0; i < 27; i++) begin : g_w2
      assign w_L2[i*W +: W] = m_w2[i];
   end
   for (genvar i = 0; i < 3; i++) begin : g_l3
      assign b_L2[i*W +: W] = m_b2[i];
      assign w_L3[i*W +: W] = m_w3[i];
   end
   assign b_L3 = m_b3;
   discriminator_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .w_L2(w_L2), .b_L2(b_L2), .w_L3(w_L3), .b_L3(b_L3),
      .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score), .out_real(out_real)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] msat(input logic signed [127:0] x);
      if (x > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (x < -128'sh80000000) return 32'h80000000;
      return x[31:0];
   endfunction
   // Reference: the network equations evaluated with wide exact integers.
   task automatic model(output logic [31:0] s, output logic r);
      logic signed [127:0] acc, o;
      int h [3];
      o = 0;
      for (int k = 0; k < 3; k++) begin
         acc = 0;
         for (int p = 0; p < 9; p++) acc += $signed(m_pix[p]) * $signed(m_w2[9*k+p]);
         h[k] = int'(msat((acc >>> 16) + $signed(m_b2[k])));
`ifdef DISC_LEAKY_RELU_EN
         if (h[k] < 0) h[k] = h[k] >>> 3;
`else
         if (h[k] < 0) h[k] = 0;
`endif
         o += 128'(h[k]) * $signed(m_w3[k]);
      end
      s = msat((o >>> 16) + $signed(m_b3));
      r = ~s[31];
   endtask
   task automatic set_uniform(input vec_t v);
      foreach (m_pix[i]) m_pix[i] = v.pix;
      foreach (m_w2[i]) m_w2[i] = v.w2;
      foreach (m_b2[i]) m_b2[i] = v.b2;
      foreach (m_w3[i]) m_w3[i] = v.w3;
      m_b3 = v.b3;
   endtask
   task automatic send(input int n, input int gap);
      int p = 0, g = 0;
      logic v, rdy;
      while (p < n && g < 500) begin
         @(negedge clk);
         rdy = in_ready;
         v = (gap == 0) || ($urandom_range(0, 2) != 0);
         in_valid = v;
         in_pixel = m_pix[p];
         @(posedge clk);
         if (v && rdy) p++;
         g++;
      end
      check("send.accepted", 64'(p), 64'(n));
   endtask
   task automatic do_frame(input string nm, input int gap, input int hold, input logic [31:0] es, input logic er);
      int n;
      logic ok;
      out_ready = (hold == 0);
      send(9, gap);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 0;
         n++;
      end while (!out_valid && n < 40);
      check({nm, ".latency"}, 64'(n - 1), 64'd5);
      check({nm, ".score"}, 64'(out_score), 64'(es));
      check({nm, ".real"}, 64'(out_real), 64'(er));
      if (hold > 0) begin
         ok = 1;
         repeat (hold) begin
            @(negedge clk);
            ok = ok & out_valid & ~in_ready & (out_score == es) & (out_real == er);
         end
         check({nm, ".hold_stable"}, 64'(ok), 64'd1);
      end
      out_ready = 1;
      @(negedge clk);
      check({nm, ".handshake"}, 64'({out_valid, in_ready}), 64'b01);
      out_ready = 0;
   endtask
   initial begin
      logic [31:0] es;
      logic er;
      tbl[0] = '{"ones", 32'h00010000, 32'h00010000, 0, 32'h00010000, 0, 32'h001B0000, 1'b1};
`ifdef DISC_LEAKY_RELU_EN
      tbl[1] = '{"negw", 32'h00010000, 32'hFFFF0000, 0, 32'h00010000, 32'hFFFF8000, 32'hFFFC2000, 1'b0};
      tbl[6] = '{"negbias", 32'h00010000, 32'h00010000, 32'hFFEC0000, 32'h00010000, 0, 32'hFFFBE000, 1'b0};
`else
      tbl[1] = '{"negw", 32'h00010000, 32'hFFFF0000, 0, 32'h00010000, 32'hFFFF8000, 32'hFFFF8000, 1'b0};
      tbl[6] = '{"negbias", 32'h00010000, 32'h00010000, 32'hFFEC0000, 32'h00010000, 0, 32'h00000000, 1'b1};
`endif
      tbl[2] = '{"satpos", 32'h7FFF0000, 32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h7FFFFFFF, 1'b1};
      tbl[3] = '{"satneg", 32'h7FFF0000, 32'h7FFF0000, 0, 32'h80010000, 0, 32'h80000000, 1'b0};
      tbl[4] = '{"mixed", 32'h00020000, 32'h00008000, 32'hFFFF0000, 32'hFFFF0000, 0, 32'hFFE80000, 1'b0};
      tbl[5] = '{"zero", 0, 0, 0, 0, 0, 32'h00000000, 1'b1};
      set_uniform(tbl[0]);
      #2 rst = 0;
      #1;
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.out_score", 64'(out_score), 64'd0);
      check("reset.out_real", 64'(out_real), 64'd0);
      @(negedge clk) rst = 1;
      foreach (tbl[i]) begin
         set_uniform(tbl[i]);
         do_frame(tbl[i].nm, 0, 0, tbl[i].es, tbl[i].er);
      end
      set_uniform(tbl[0]);
      do_frame("hold10", 0, 10, tbl[0].es, tbl[0].er);
      foreach (m_pix[i]) m_pix[i] = 32'h00050000;
      send(4, 1);
      @(negedge clk);
      in_valid = 0;
      #2 rst = 0;
      #1 check("midrst.outs", 64'({in_ready, out_valid, out_real, out_score}), 64'({3'b100, 32'h0}));
      @(negedge clk) rst = 1;
      set_uniform(tbl[0]);
      do_frame("after_rst", 1, 0, tbl[0].es, tbl[0].er);
      for (int t = 0; t < 20; t++) begin
         foreach (m_pix[i]) m_pix[i] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h7FFFF) - 32'h40000;
         foreach (m_w2[i]) m_w2[i] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h7FFFF) - 32'h40000;
         foreach (m_b2[i]) m_b2[i] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
         foreach (m_w3[i]) m_w3[i] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
         m_b3 = $urandom_range(0, 32'h7FFFF) - 32'h40000;
         model(es, er);
         do_frame($sformatf("rand%0d", t), 1, $urandom_range(0, 3), es, er);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
